phy_mgmt_ctrl: RTL and testbench

- Management sequencer for PHY0, placed between the system logic and the MDIO transaction engine in the top level.
- After reset it waits for the PHY power-up delay, soft-resets the PHY and writes the configured BMCR value.
- It then periodically polls BMSR to report link state.
- In the run phase it shares the single MDIO engine between host register requests and the internal link poll.

---
 rtl/phy_mgmt_pkg.sv | 37 +++
 rtl/phy_mgmt_ctrl_if.sv | 37 +++
 rtl/phy_mgmt_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_phy_mgmt_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_mgmt_pkg.sv
// Shared types and constants for the PHY0 management sequencer.
package phy_mgmt_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_INIT_RST  = 3'd1,
        S_INIT_POLL = 3'd2,
        S_INIT_CFG  = 3'd3,
        S_IDLE      = 3'd4,
        S_POLL      = 3'd5,
        S_HOST      = 3'd6
    } state_e;

    // Reset value GNT_HOST makes the first poll/host tie go to the poll.
    typedef enum logic {
        GNT_HOST = 1'b0,
        GNT_POLL = 1'b1
    } grant_e;

    localparam logic [1:0]  MDIO_OP_NONE   = 2'b00;
    localparam logic [1:0]  MDIO_OP_WRITE  = 2'b01;
    localparam logic [1:0]  MDIO_OP_READ   = 2'b10;

    localparam logic [4:0]  REG_BMCR       = 5'd0;
    localparam logic [4:0]  REG_BMSR       = 5'd1;

    localparam logic [15:0] BMCR_RESET     = 16'h8000;
    localparam int unsigned BMCR_RESET_BIT = 15;
    localparam int unsigned BMSR_LINK_BIT  = 2;

    // True for states that own an outstanding MDIO transaction.
    function automatic logic is_xact(input state_e s);
        return (s == S_INIT_RST) || (s == S_INIT_POLL) || (s == S_INIT_CFG) ||
               (s == S_POLL) || (s == S_HOST);
    endfunction

endpackage

// File: rtl/phy_mgmt_ctrl_if.sv
// MDIO engine and host register bus bundle.
// master: the sequencer (drives MDIO requests, answers host requests).
// slave : the environment (MDIO engine plus host).
interface phy_mgmt_ctrl_if;

    logic        mdio_en;
    logic [1:0]  mdio_op;
    logic [4:0]  mdio_phyad;
    logic [4:0]  mdio_regad;
    logic [15:0] mdio_wdata;
    logic        mdio_valid;
    logic [15:0] mdio_rdata;

    logic        host_req_valid;
    logic        host_req_ready;
    logic        host_req_write;
    logic [4:0]  host_req_regad;
    logic [15:0] host_req_wdata;
    logic        host_rsp_valid;
    logic [15:0] host_rsp_rdata;
    logic        host_rsp_err;

    modport master (
        output mdio_en, mdio_op, mdio_phyad, mdio_regad, mdio_wdata,
        input  mdio_valid, mdio_rdata,
        input  host_req_valid, host_req_write, host_req_regad, host_req_wdata,
        output host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err
    );

    modport slave (
        input  mdio_en, mdio_op, mdio_phyad, mdio_regad, mdio_wdata,
        output mdio_valid, mdio_rdata,
        output host_req_valid, host_req_write, host_req_regad, host_req_wdata,
        input  host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err
    );

endinterface

// File: rtl/phy_mgmt_ctrl.sv
// PHY0 management sequencer: power-up delay, BMCR soft reset and configure,
// periodic BMSR link poll, and arbitration of the MDIO engine between the
// link poll and host register requests.
// Ports: clk, rst_n (async active-low); bus (master side of phy_mgmt_ctrl_if:
// MDIO request/completion and host request/response); init_done, link_up,
// err_timeout status outputs.
module phy_mgmt_ctrl
    import phy_mgmt_pkg::*;
#(
    parameter logic [4:0]  PHYAD        = 5'd0,
    parameter int unsigned RESET_DELAY  = 250000,
    parameter int unsigned POLL_PERIOD  = 2500000,
    parameter int unsigned TIMEOUT      = 4096,
    parameter int unsigned RST_POLL_MAX = 16,
    parameter logic [15:0] INIT_BMCR    = 16'h1200
) (
    input  logic             clk,
    input  logic             rst_n,
    phy_mgmt_ctrl_if.master  bus,
    output logic             init_done,
    output logic             link_up,
    output logic             err_timeout
);

    localparam int unsigned CNT_MAX = (RESET_DELAY > POLL_PERIOD) ? RESET_DELAY : POLL_PERIOD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned RP_W    = $clog2(RST_POLL_MAX + 1);

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(RESET_DELAY - 1);
    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [RP_W-1:0]  RP_LAST    = RP_W'(RST_POLL_MAX - 1);

    state_e           state_q,        state_d;
    logic [CNT_W-1:0] cnt_q,          cnt_d;
    logic [TO_W-1:0]  to_cnt_q,       to_cnt_d;
    logic [RP_W-1:0]  rp_cnt_q,       rp_cnt_d;
    logic             poll_pending_q, poll_pending_d;
    grant_e           last_grant_q,   last_grant_d;
    logic             mdio_en_q,      mdio_en_d;
    logic [1:0]       mdio_op_q,      mdio_op_d;
    logic [4:0]       mdio_phyad_q,   mdio_phyad_d;
    logic [4:0]       mdio_regad_q,   mdio_regad_d;
    logic [15:0]      mdio_wdata_q,   mdio_wdata_d;
    logic             rsp_valid_q,    rsp_valid_d;
    logic [15:0]      rsp_rdata_q,    rsp_rdata_d;
    logic             rsp_err_q,      rsp_err_d;
    logic             init_done_q,    init_done_d;
    logic             link_up_q,      link_up_d;
    logic             err_timeout_q,  err_timeout_d;

    logic             host_ready;
    logic             xact_to;
    logic             issue;
    state_e           iss_state;
    logic [1:0]       iss_op;
    logic [4:0]       iss_regad;
    logic [15:0]      iss_wdata;
    logic             init_fail;

    // A pending poll owed after a host grant blocks the host.
    assign host_ready = (state_q == S_IDLE) && !(poll_pending_q && (last_grant_q == GNT_HOST));
    // Completion wins over a timeout landing on the same cycle.
    assign xact_to    = !bus.mdio_valid && (to_cnt_q == TO_LAST);

    // Next-state and output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        to_cnt_d       = to_cnt_q;
        rp_cnt_d       = rp_cnt_q;
        poll_pending_d = poll_pending_q;
        last_grant_d   = last_grant_q;
        mdio_en_d      = 1'b0;
        mdio_op_d      = mdio_op_q;
        mdio_phyad_d   = mdio_phyad_q;
        mdio_regad_d   = mdio_regad_q;
        mdio_wdata_d   = mdio_wdata_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_err_d      = rsp_err_q;
        init_done_d    = init_done_q;
        link_up_d      = link_up_q;
        err_timeout_d  = err_timeout_q;
        issue          = 1'b0;
        iss_state      = state_q;
        iss_op         = MDIO_OP_NONE;
        iss_regad      = 5'd0;
        iss_wdata      = 16'h0000;
        init_fail      = 1'b0;

        if (is_xact(state_q)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        case (state_q)
            S_WAIT: begin
                if (cnt_q == DELAY_LAST) begin
                    cnt_d     = '0;
                    issue     = 1'b1;
                    iss_state = S_INIT_RST;
                    iss_op    = MDIO_OP_WRITE;
                    iss_regad = REG_BMCR;
                    iss_wdata = BMCR_RESET;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_INIT_RST: begin
                if (bus.mdio_valid) begin
                    rp_cnt_d  = '0;
                    issue     = 1'b1;
                    iss_state = S_INIT_POLL;
                    iss_op    = MDIO_OP_READ;
                    iss_regad = REG_BMCR;
                end else if (xact_to) begin
                    init_fail = 1'b1;
                end
            end
            S_INIT_POLL: begin
                if (bus.mdio_valid) begin
                    if (!bus.mdio_rdata[BMCR_RESET_BIT]) begin
                        issue     = 1'b1;
                        iss_state = S_INIT_CFG;
                        iss_op    = MDIO_OP_WRITE;
                        iss_regad = REG_BMCR;
                        iss_wdata = INIT_BMCR;
                    end else if (rp_cnt_q == RP_LAST) begin
                        init_fail = 1'b1;
                    end else begin
                        rp_cnt_d  = rp_cnt_q + RP_W'(1);
                        issue     = 1'b1;
                        iss_state = S_INIT_POLL;
                        iss_op    = MDIO_OP_READ;
                        iss_regad = REG_BMCR;
                    end
                end else if (xact_to) begin
                    init_fail = 1'b1;
                end
            end
            S_INIT_CFG: begin
                if (bus.mdio_valid) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (xact_to) begin
                    init_fail = 1'b1;
                end
            end
            S_IDLE: begin
                if (bus.host_req_valid && host_ready) begin
                    last_grant_d = GNT_HOST;
                    issue        = 1'b1;
                    iss_state    = S_HOST;
                    iss_op       = bus.host_req_write ? MDIO_OP_WRITE : MDIO_OP_READ;
                    iss_regad    = bus.host_req_regad;
                    iss_wdata    = bus.host_req_write ? bus.host_req_wdata : 16'h0000;
                end else if (poll_pending_q) begin
                    last_grant_d   = GNT_POLL;
                    poll_pending_d = 1'b0;
                    issue          = 1'b1;
                    iss_state      = S_POLL;
                    iss_op         = MDIO_OP_READ;
                    iss_regad      = REG_BMSR;
                end
            end
            S_POLL: begin
                if (bus.mdio_valid) begin
                    link_up_d = bus.mdio_rdata[BMSR_LINK_BIT];
                    state_d   = S_IDLE;
                end else if (xact_to) begin
                    link_up_d     = 1'b0;
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_HOST: begin
                if (bus.mdio_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (mdio_op_q == MDIO_OP_READ) ? bus.mdio_rdata : 16'h0000;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end else if (xact_to) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 16'h0000;
                    rsp_err_d     = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_WAIT;
        endcase

        // Any init failure restarts the soft reset with no delay.
        if (init_fail) begin
            err_timeout_d = 1'b1;
            rp_cnt_d      = '0;
            issue         = 1'b1;
            iss_state     = S_INIT_RST;
            iss_op        = MDIO_OP_WRITE;
            iss_regad     = REG_BMCR;
            iss_wdata     = BMCR_RESET;
        end

        if (issue) begin
            state_d      = iss_state;
            mdio_en_d    = 1'b1;
            mdio_op_d    = iss_op;
            mdio_phyad_d = PHYAD;
            mdio_regad_d = iss_regad;
            mdio_wdata_d = iss_wdata;
            to_cnt_d     = '0;
        end

        // Poll timer; a terminal count while already pending merges into it.
        if (init_done_q) begin
            if (cnt_q == POLL_LAST) begin
                cnt_d          = '0;
                poll_pending_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_WAIT;
            cnt_q          <= '0;
            to_cnt_q       <= '0;
            rp_cnt_q       <= '0;
            poll_pending_q <= 1'b0;
            last_grant_q   <= GNT_HOST;
            mdio_en_q      <= 1'b0;
            mdio_op_q      <= MDIO_OP_NONE;
            mdio_phyad_q   <= 5'd0;
            mdio_regad_q   <= 5'd0;
            mdio_wdata_q   <= 16'h0000;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= 16'h0000;
            rsp_err_q      <= 1'b0;
            init_done_q    <= 1'b0;
            link_up_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            to_cnt_q       <= to_cnt_d;
            rp_cnt_q       <= rp_cnt_d;
            poll_pending_q <= poll_pending_d;
            last_grant_q   <= last_grant_d;
            mdio_en_q      <= mdio_en_d;
            mdio_op_q      <= mdio_op_d;
            mdio_phyad_q   <= mdio_phyad_d;
            mdio_regad_q   <= mdio_regad_d;
            mdio_wdata_q   <= mdio_wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
            init_done_q    <= init_done_d;
            link_up_q      <= link_up_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign bus.mdio_en        = mdio_en_q;
    assign bus.mdio_op        = mdio_op_q;
    assign bus.mdio_phyad     = mdio_phyad_q;
    assign bus.mdio_regad     = mdio_regad_q;
    assign bus.mdio_wdata     = mdio_wdata_q;
    assign bus.host_req_ready = host_ready;
    assign bus.host_rsp_valid = rsp_valid_q;
    assign bus.host_rsp_rdata = rsp_rdata_q;
    assign bus.host_rsp_err   = rsp_err_q;
    assign init_done          = init_done_q;
    assign link_up            = link_up_q;
    assign err_timeout        = err_timeout_q;

endmodule

// File: tb/tb_phy_mgmt_ctrl.sv
// Self-checking bench for phy_mgmt_ctrl with a behavioural MDIO engine that
// answers 5 cycles after each mdio_en.
module tb_phy_mgmt_ctrl;
    import phy_mgmt_pkg::*;

    localparam int unsigned T_RESET_DELAY = 10;
    localparam int unsigned T_POLL_PERIOD = 200;
    localparam int unsigned T_TIMEOUT     = 50;

    logic clk;
    logic rst_n;
    logic init_done, link_up, err_timeout;
    int   cyc;

    phy_mgmt_ctrl_if bus();

    phy_mgmt_ctrl #(
        .PHYAD        (5'd0),
        .RESET_DELAY  (T_RESET_DELAY),
        .POLL_PERIOD  (T_POLL_PERIOD),
        .TIMEOUT      (T_TIMEOUT),
        .RST_POLL_MAX (4),
        .INIT_BMCR    (16'h1200)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .init_done   (init_done),
        .link_up     (link_up),
        .err_timeout (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- MDIO engine model ----------------
    typedef struct {
        logic [1:0]  op;
        logic [4:0]  regad;
        logic [15:0] wdata;
        logic [4:0]  phyad;
        int          cyc;
    } txn_t;

    txn_t        log_q[$];
    logic [15:0] bmcr_q[$];
    logic [15:0] bmsr_val;
    int          last_resp_cyc;
    int          last_host_en_cyc;
    int          n_poll_rsp;
    txn_t        eng_t;
    logic [15:0] eng_rd;
    bit          eng_drop;

    initial begin
        bus.mdio_valid   = 1'b0;
        bus.mdio_rdata   = 16'h0000;
        last_resp_cyc    = -1;
        last_host_en_cyc = -1;
        n_poll_rsp       = 0;
        forever begin
            @(posedge clk); #1;
            while (bus.mdio_en === 1'b1) begin
                eng_t.op    = bus.mdio_op;
                eng_t.regad = bus.mdio_regad;
                eng_t.wdata = bus.mdio_wdata;
                eng_t.phyad = bus.mdio_phyad;
                eng_t.cyc   = cyc;
                log_q.push_back(eng_t);
                if (eng_t.regad > 5'd1) last_host_en_cyc = cyc;
                eng_rd = 16'h0000;
                if (eng_t.op == MDIO_OP_READ) begin
                    case (eng_t.regad)
                        5'd0:    eng_rd = (bmcr_q.size() > 0) ? bmcr_q.pop_front() : 16'h0000;
                        5'd1:    eng_rd = bmsr_val;
                        5'd2:    eng_rd = 16'h0141;
                        default: eng_rd = 16'h0000;
                    endcase
                end
                eng_drop = (eng_t.op == MDIO_OP_WRITE) && (eng_t.regad == 5'd5);
                repeat (5) @(posedge clk);
                #1;
                if (!eng_drop) begin
                    bus.mdio_valid = 1'b1;
                    bus.mdio_rdata = eng_rd;
                    last_resp_cyc  = cyc;
                    if (eng_t.regad == 5'd1) n_poll_rsp++;
                    @(posedge clk); #1;
                    bus.mdio_valid = 1'b0;
                    bus.mdio_rdata = 16'h0000;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk;
    int n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [4:0]  regad;
        logic [15:0] wdata;
    } exp_txn_t;

    exp_txn_t boot_tab[9];

    task automatic check_boot(input int start, input int first, input int n);
        logic [27:0] got;
        for (int i = 0; i < n; i++) begin
            if (start + i < log_q.size()) begin
                got = {log_q[start+i].op, log_q[start+i].regad,
                       (log_q[start+i].op == MDIO_OP_WRITE) ? log_q[start+i].wdata : 16'h0000,
                       log_q[start+i].phyad};
            end else begin
                got = '1;
            end
            check(boot_tab[first+i].name, 32'(got),
                  32'({boot_tab[first+i].op, boot_tab[first+i].regad, boot_tab[first+i].wdata, 5'd0}));
        end
        check("boot_txn_count", 32'(log_q.size() - start), 32'(n));
    endtask

    task automatic wait_init(output int at_cyc, output bit ok);
        ok = 0;
        at_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (init_done === 1'b1) begin
                ok = 1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic host_xact(input logic w, input logic [4:0] ra, input logic [15:0] wd,
                             output logic [15:0] rd, output logic er,
                             output int hs_cyc, output int rsp_cyc, output bit ok);
        logic acc;
        ok = 0; hs_cyc = -1; rsp_cyc = -1; rd = 16'hxxxx; er = 1'bx;
        bus.host_req_valid = 1'b1;
        bus.host_req_write = w;
        bus.host_req_regad = ra;
        bus.host_req_wdata = wd;
        for (int i = 0; i < 400; i++) begin
            acc = bus.host_req_ready;
            @(posedge clk); #1;
            if (acc === 1'b1) begin
                hs_cyc = cyc;
                break;
            end
        end
        bus.host_req_valid = 1'b0;
        if (hs_cyc < 0) return;
        for (int i = 0; i < 200; i++) begin
            if (bus.host_rsp_valid === 1'b1) begin
                rd = bus.host_rsp_rdata;
                er = bus.host_rsp_err;
                rsp_cyc = cyc;
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    logic ready_hist[16384];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rel_cyc, start, init_cyc, hs, rc, ws, we;
        int          polls, hosts, adj_bad, rdy_bad;
        logic [15:0] rd;
        logic        er;
        bit          ok;
        logic [4:0]  prev_reg;

        boot_tab[0] = '{"boot1_w8000", MDIO_OP_WRITE, REG_BMCR, 16'h8000};
        boot_tab[1] = '{"boot1_rd0_a", MDIO_OP_READ,  REG_BMCR, 16'h0000};
        boot_tab[2] = '{"boot1_rd0_b", MDIO_OP_READ,  REG_BMCR, 16'h0000};
        boot_tab[3] = '{"boot1_rd0_c", MDIO_OP_READ,  REG_BMCR, 16'h0000};
        boot_tab[4] = '{"boot1_w1200", MDIO_OP_WRITE, REG_BMCR, 16'h1200};
        boot_tab[5] = '{"boot2_w8000", MDIO_OP_WRITE, REG_BMCR, 16'h8000};
        boot_tab[6] = '{"boot2_rd0_a", MDIO_OP_READ,  REG_BMCR, 16'h0000};
        boot_tab[7] = '{"boot2_rd0_b", MDIO_OP_READ,  REG_BMCR, 16'h0000};
        boot_tab[8] = '{"boot2_w1200", MDIO_OP_WRITE, REG_BMCR, 16'h1200};

        n_chk = 0; n_pass = 0;
        rst_n = 1'b1;
        bus.host_req_valid = 1'b0;
        bus.host_req_write = 1'b0;
        bus.host_req_regad = 5'd0;
        bus.host_req_wdata = 16'h0000;
        bmsr_val = 16'h7809;
        bmcr_q = '{16'h8000, 16'h8000, 16'h1000};
        #1 rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mdio_en",     32'(bus.mdio_en), 32'h0);
        check("rst_mdio_op",     32'(bus.mdio_op), 32'h0);
        check("rst_init_done",   32'(init_done), 32'h0);
        check("rst_link_up",     32'(link_up), 32'h0);
        check("rst_err_timeout", 32'(err_timeout), 32'h0);
        check("rst_rsp_valid",   32'(bus.host_rsp_valid), 32'h0);
        check("rst_req_ready",   32'(bus.host_req_ready), 32'h0);

        // Boot
        rst_n = 1'b1;
        rel_cyc = cyc;
        start = log_q.size();
        wait_init(init_cyc, ok);
        check("boot1_init_done", 32'(ok), 32'h1);
        check("boot1_first_en_delay", (log_q.size() > start) ? 32'(log_q[start].cyc - rel_cyc) : 32'hffff_ffff, 32'd10);
        check_boot(start, 0, 5);
        check("boot1_init_after_valid", 32'(init_cyc), 32'(last_resp_cyc + 1));
        check("boot1_no_timeout", 32'(err_timeout), 32'h0);

        // Link poll: BMSR without link, then with link
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (n_poll_rsp >= 1) begin ok = 1; break; end
        end
        check("poll1_seen", 32'(ok), 32'h1);
        @(posedge clk); #1;
        check("poll1_link_down", 32'(link_up), 32'h0);
        bmsr_val = 16'h782D;
        ok = 0;
        for (int i = 0; i < T_POLL_PERIOD + 10; i++) begin
            @(posedge clk); #1;
            if (link_up === 1'b1) begin ok = 1; break; end
        end
        check("poll2_link_up", 32'(ok), 32'h1);

        // Host read of reg 2
        host_xact(1'b0, 5'd2, 16'h0000, rd, er, hs, rc, ok);
        check("hrd_complete", 32'(ok), 32'h1);
        check("hrd_rdata", 32'(rd), 32'h0141);
        check("hrd_err", 32'(er), 32'h0);
        check("hrd_en_latency", 32'(last_host_en_cyc), 32'(hs));
        check("hrd_rsp_latency", 32'(rc), 32'(last_resp_cyc + 1));

        // Contention: host request held high across several poll periods
        repeat (3) @(posedge clk);
        #1;
        start = log_q.size();
        bus.host_req_valid = 1'b1;
        bus.host_req_write = 1'b0;
        bus.host_req_regad = 5'd2;
        ws = cyc;
        for (int i = 0; i < 450; i++) begin
            ready_hist[cyc % 16384] = bus.host_req_ready;
            @(posedge clk); #1;
        end
        we = cyc;
        bus.host_req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        polls = 0; hosts = 0; adj_bad = 0; rdy_bad = 0; prev_reg = 5'd2;
        for (int i = start; i < log_q.size(); i++) begin
            if (log_q[i].cyc > we) break;
            if (log_q[i].regad == REG_BMSR) begin
                polls++;
                if (prev_reg == REG_BMSR) adj_bad++;
                if (log_q[i].cyc - 1 >= ws && ready_hist[(log_q[i].cyc - 1) % 16384] !== 1'b0) rdy_bad++;
            end else begin
                hosts++;
            end
            prev_reg = log_q[i].regad;
        end
        check("cont_polls_granted", 32'(polls >= 2), 32'h1);
        check("cont_hosts_served", 32'(hosts >= 20), 32'h1);
        check("cont_poll_then_host", 32'(adj_bad), 32'h0);
        check("cont_ready_low_when_owed", 32'(rdy_bad), 32'h0);

        // Timeout on a dropped host write, then a normal read
        host_xact(1'b1, 5'd5, 16'hABCD, rd, er, hs, rc, ok);
        check("hto_complete", 32'(ok), 32'h1);
        check("hto_err", 32'(er), 32'h1);
        check("hto_rdata", 32'(rd), 32'h0);
        check("hto_latency", 32'(rc - last_host_en_cyc), 32'd50);
        check("hto_sticky", 32'(err_timeout), 32'h1);
        host_xact(1'b0, 5'd2, 16'h0000, rd, er, hs, rc, ok);
        check("after_to_complete", 32'(ok), 32'h1);
        check("after_to_rdata", 32'(rd), 32'h0141);
        check("after_to_err", 32'(er), 32'h0);
        check("after_to_sticky", 32'(err_timeout), 32'h1);

        // Reset from the run phase: outputs clear at once
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rrun_link_up", 32'(link_up), 32'h0);
        check("rrun_err_timeout", 32'(err_timeout), 32'h0);
        check("rrun_init_done", 32'(init_done), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        bmcr_q.delete();
        bmcr_q.push_back(16'h8000);
        rst_n = 1'b1;

        // Reset again while waiting on a BMCR read during init
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.mdio_en === 1'b1 && bus.mdio_op == MDIO_OP_READ && bus.mdio_regad == REG_BMCR) begin
                ok = 1;
                break;
            end
        end
        check("rinit_read_seen", 32'(ok), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rinit_mdio_op", 32'(bus.mdio_op), 32'h0);
        check("rinit_mdio_en", 32'(bus.mdio_en), 32'h0);
        check("rinit_init_done", 32'(init_done), 32'h0);
        bmcr_q.delete();
        bmcr_q.push_back(16'h8000);
        bmcr_q.push_back(16'h1000);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel_cyc = cyc;
        start = log_q.size();
        wait_init(init_cyc, ok);
        check("boot2_init_done", 32'(ok), 32'h1);
        check("boot2_first_en_delay", (log_q.size() > start) ? 32'(log_q[start].cyc - rel_cyc) : 32'hffff_ffff, 32'd10);
        check_boot(start, 5, 4);
        check("boot2_no_timeout", 32'(err_timeout), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
